sub_pipe_nbit: RTL and testbench

SUB_PIPE_NBIT -- requirements
Module: sub_pipe_nbit

---
 rtl/sub_pipe_pkg.sv | 37 +++
 rtl/sub_slice.sv | 21 ++
 rtl/sub_pipe_nbit.sv | 120 ++++++++++++
 tb/tb_sub_pipe_nbit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/sub_pipe_pkg.sv
// rtl/sub_pipe_pkg.sv - mode encoding, stage record and saturation constants for sub_pipe_nbit
package sub_pipe_pkg;

  // Widest operand the stage record can carry; the top module checks WIDTH against it.
  localparam int SUB_MAX_W = 64;

  typedef enum logic {
    SUB_MODE_UNSIGNED = 1'b0,
    SUB_MODE_SIGNED   = 1'b1
  } sub_mode_e;

  // a_rem/b_rem hold the operand slices not yet consumed, LSB slice at bit 0.
  typedef struct packed {
    logic                 valid;
    logic [SUB_MAX_W-1:0] a_rem;
    logic [SUB_MAX_W-1:0] b_rem;
    logic [SUB_MAX_W-1:0] diff;
    logic                 borrow;
    logic                 overflow;
    sub_mode_e            mode;
  } sub_rec_t;

  function automatic logic [SUB_MAX_W-1:0] sat_max(input int width);
    logic [SUB_MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < width - 1; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [SUB_MAX_W-1:0] sat_min(input int width);
    logic [SUB_MAX_W-1:0] v;
    v = '0;
    v[width-1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/sub_slice.sv
// rtl/sub_slice.sv - combinational W-bit slice computing a - b - bin with borrow out
module sub_slice
  import sub_pipe_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic [W-1:0] diff,
  output logic         bout
);

  logic [W:0] full;

  // The extra top bit goes to 1 exactly when the slice needs to borrow.
  assign full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
  assign diff = full[W-1:0];
  assign bout = full[W];

endmodule

// File: rtl/sub_pipe_nbit.sv
// rtl/sub_pipe_nbit.sv - STAGES-deep sliced subtractor with valid/ready flow control and overflow counter
// Define SUB_PIPE_SAT_EN to saturate overflowing results instead of wrapping.
module sub_pipe_nbit
  import sub_pipe_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_borrow,
  output logic             out_overflow,
  output logic [CNT_W-1:0] ovf_cnt
);

  localparam int SW = WIDTH / STAGES;

  if (WIDTH < 4 || WIDTH > SUB_MAX_W || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("sub_pipe_nbit: WIDTH must be 4..64 and a multiple of STAGES");
  end

  sub_rec_t st  [STAGES];
  sub_rec_t nxt [STAGES];
  sub_rec_t in_rec;
  logic     en;
  logic     unused_tail;

  assign out_valid    = st[STAGES-1].valid;
  assign out_diff     = st[STAGES-1].diff[WIDTH-1:0];
  assign out_borrow   = st[STAGES-1].borrow;
  assign out_overflow = st[STAGES-1].overflow;
  assign en           = !out_valid || out_ready;
  assign in_ready     = en;

  // Exhausted operand remainders and diff bits above WIDTH leave the last stage unread.
  assign unused_tail = ^{st[STAGES-1].a_rem, st[STAGES-1].b_rem, st[STAGES-1].diff, st[STAGES-1].mode};

  always_comb begin
    in_rec       = '0;
    in_rec.valid = in_valid;
    in_rec.a_rem = SUB_MAX_W'(in_a);
    in_rec.b_rem = SUB_MAX_W'(in_b);
    in_rec.mode  = in_signed ? SUB_MODE_SIGNED : SUB_MODE_UNSIGNED;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    sub_rec_t      src;
    sub_rec_t      rec;
    logic [SW-1:0] d;
    logic          bout;

    if (k == 0) begin : g_first
      assign src = in_rec;
    end else begin : g_next
      assign src = st[k-1];
    end

    sub_slice #(.W(SW)) u_slice (
      .a    (src.a_rem[SW-1:0]),
      .b    (src.b_rem[SW-1:0]),
      .bin  (src.borrow),
      .diff (d),
      .bout (bout)
    );

    always_comb begin
      rec                  = src;
      rec.a_rem            = src.a_rem >> SW;
      rec.b_rem            = src.b_rem >> SW;
      rec.diff[k*SW +: SW] = d;
      rec.borrow           = bout;
      rec.overflow         = 1'b0;
      // The last stage sees the operand MSBs in its slice, so overflow is resolved here.
      if (k == STAGES - 1) begin
        if (src.mode == SUB_MODE_SIGNED) begin
          rec.overflow = (src.a_rem[SW-1] ^ src.b_rem[SW-1]) & (d[SW-1] ^ src.a_rem[SW-1]);
        end else begin
          rec.overflow = bout;
        end
`ifdef SUB_PIPE_SAT_EN
        if (rec.overflow) begin
          if (src.mode == SUB_MODE_SIGNED) begin
            rec.diff = src.a_rem[SW-1] ? sat_min(WIDTH) : sat_max(WIDTH);
          end else begin
            rec.diff = '0;
          end
        end
`endif
      end
    end

    assign nxt[k] = rec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) st[i] <= '0;
    end else if (en) begin
      for (int i = 0; i < STAGES; i++) st[i] <= nxt[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_cnt <= '0;
    end else if (out_valid && out_ready && out_overflow && (ovf_cnt != {CNT_W{1'b1}})) begin
      ovf_cnt <= ovf_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sub_pipe_nbit.sv
// tb/tb_sub_pipe_nbit.sv - directed-vector bench for sub_pipe_nbit (WIDTH=16, STAGES=4, CNT_W=8)
// Expected diffs follow SUB_PIPE_SAT_EN when the bench is built with it defined.
module tb_sub_pipe_nbit;

  localparam int WIDTH  = 16;
  localparam int STAGES = 4;
  localparam int CNT_W  = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_signed;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_diff;
  logic             out_borrow;
  logic             out_overflow;
  logic [CNT_W-1:0] ovf_cnt;

  always #5 clk = ~clk;

  sub_pipe_nbit #(.WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_signed    (in_signed),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_diff     (out_diff),
    .out_borrow   (out_borrow),
    .out_overflow (out_overflow),
    .ovf_cnt      (ovf_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [15:0] va [8];
  logic [15:0] vb [8];
  logic        vs [8];
  logic [15:0] vd [8];
  logic        vbr[8];
  logic        vo [8];

  task automatic set_vec(input int i, input logic [15:0] a, input logic [15:0] b, input logic s,
                         input logic [15:0] d, input logic br, input logic o);
    va[i] = a; vb[i] = b; vs[i] = s; vd[i] = d; vbr[i] = br; vo[i] = o;
  endtask

  // Streams vectors (start+i)%8; vmask/rmask gate in_valid/out_ready for cycles 0..31.
  task automatic run(input string name, input int start, input int nvec,
                     input logic [31:0] vmask, input logic [31:0] rmask,
                     output int first_out, output int stalls);
    int sent;
    int got;
    int idx;
    sent = 0; got = 0; first_out = -1; stalls = 0;
    for (int c = 0; c < 200 && got < nvec; c++) begin
      @(negedge clk);
      out_ready = (c >= 32) || rmask[c & 31];
      in_valid  = (sent < nvec) && ((c >= 32) || vmask[c & 31]);
      idx       = (start + sent) % 8;
      in_a      = va[idx];
      in_b      = vb[idx];
      in_signed = vs[idx];
      #1;
      if (out_valid) begin
        idx = (start + got) % 8;
        check({name, "_diff"},   32'(out_diff),     32'(vd[idx]));
        check({name, "_borrow"}, 32'(out_borrow),   32'(vbr[idx]));
        check({name, "_ovf"},    32'(out_overflow), 32'(vo[idx]));
        if (first_out < 0) first_out = c;
        if (out_ready) got++;
      end
      if (!in_ready) stalls++;
      if (in_valid && in_ready) sent++;
    end
    check({name, "_count"}, 32'(got), 32'(nvec));
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check({name, "_idle"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int first_out;
    int stalls;
    int sent;
    int vcount;

    set_vec(0, 16'h1234, 16'h0FFF, 1'b0, 16'h0235, 1'b0, 1'b0);
    set_vec(1, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b0, 1'b1);
    set_vec(2, 16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1'b1, 1'b1);
    set_vec(3, 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b1, 1'b0);
    set_vec(4, 16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 1'b1, 1'b1);
    set_vec(5, 16'hFFFF, 16'h0001, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    set_vec(6, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
    set_vec(7, 16'h0100, 16'h00FF, 1'b1, 16'h0001, 1'b0, 1'b0);
`ifdef SUB_PIPE_SAT_EN
    vd[1] = 16'h8000;
    vd[2] = 16'h0000;
    vd[4] = 16'h7FFF;
`endif

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_signed = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready",  32'(in_ready),     32'd1);
    check("rst_out_valid", 32'(out_valid),    32'd0);
    check("rst_diff",      32'(out_diff),     32'd0);
    check("rst_borrow",    32'(out_borrow),   32'd0);
    check("rst_ovf",       32'(out_overflow), 32'd0);
    check("rst_ovf_cnt",   32'(ovf_cnt),      32'd0);

    // Back-to-back, consumer always ready.
    run("b2b", 0, 8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, first_out, stalls);
    check("b2b_latency", 32'(first_out), 32'd4);
    check("b2b_stalls",  32'(stalls),    32'd0);
    check("b2b_ovf_cnt", 32'(ovf_cnt),   32'd3);

    // Full pipe, consumer stalls cycles 4..6.
    run("stall", 0, 6, 32'hFFFF_FFFF, ~32'h0000_0070, first_out, stalls);
    check("stall_latency", 32'(first_out), 32'd4);
    check("stall_cycles",  32'(stalls),    32'd3);
    check("stall_ovf_cnt", 32'(ovf_cnt),   32'd6);

    // Bubbles on the input and a short consumer stall.
    run("bub", 3, 5, 32'h5555_5555, 32'hFFFF_F3FF, first_out, stalls);
    check("bub_latency", 32'(first_out), 32'd4);
    check("bub_ovf_cnt", 32'(ovf_cnt),   32'd7);

    // Reset with three operations in flight.
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      in_valid  = (c < 3);
      in_a      = va[(c == 2) ? 4 : c + 1];
      in_b      = vb[(c == 2) ? 4 : c + 1];
      in_signed = vs[(c == 2) ? 4 : c + 1];
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_pre_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    #1;
    check("mid_out_valid", 32'(out_valid), 32'd0);
    check("mid_ovf_cnt",   32'(ovf_cnt),   32'd0);
    check("mid_in_ready",  32'(in_ready),  32'd1);
    rst = 1'b0;
    out_ready = 1'b1;
    vcount = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      #1;
      if (out_valid) vcount++;
    end
    check("mid_no_ghosts", 32'(vcount), 32'd0);

    // Overflow counter saturation.
    sent = 0;
    for (int c = 0; c < 400 && sent < 300; c++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = va[1]; in_b = vb[1]; in_signed = vs[1];
      #1;
      if (in_ready) sent++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (STAGES + 2) @(negedge clk);
    #1;
    check("sat_sent",    32'(sent),    32'd300);
    check("sat_ovf_cnt", 32'(ovf_cnt), 32'd255);
    sent = 0;
    for (int c = 0; c < 50 && sent < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      #1;
      if (in_ready) sent++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (STAGES + 2) @(negedge clk);
    #1;
    check("sat_ovf_hold", 32'(ovf_cnt), 32'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
